// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// The datapath side drives opcode and ALU flag; the controller drives enables, selects and debug state.
interface multi_cycle_ctrl_if;
    logic [5:0] op;
    logic       zero;
    logic       PCWre;
    logic       IRWre;
    logic       ExtSel;
    logic       ALUSrcB;
    logic       DBDataSrc;
    logic       RegWre;
    logic       WrRegDSrc;
    logic       mRD;
    logic       mWR;
    logic [1:0] RegDst;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic [2:0] state;

    modport master (
        output op, zero,
        input  PCWre, IRWre, ExtSel, ALUSrcB, DBDataSrc, RegWre, WrRegDSrc,
               mRD, mWR, RegDst, PCSrc, ALUOp, state
    );

    modport slave (
        input  op, zero,
        output PCWre, IRWre, ExtSel, ALUSrcB, DBDataSrc, RegWre, WrRegDSrc,
               mRD, mWR, RegDst, PCSrc, ALUOp, state
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB per opcode class and
// decodes datapath enables/selects combinationally from state and opcode.
//
//   state  | meaning
//   IF     | 000 fetch, IR write
//   ID     | 001 decode; jumps/NOP retire here; with halt_q set this is HALT
//   EXE_A  | 110 R/I arithmetic execute
//   EXE_B  | 101 branch compare, retires
//   EXE_L  | 010 load/store address calc
//   MEM    | 011 memory access; sw retires
//   WB_A   | 111 arithmetic write-back
//   WB_L   | 100 load write-back
module multi_cycle_ctrl (
    input  logic                 CLK,
    input  logic                 Reset,
    multi_cycle_ctrl_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IF    = 3'b000,
        S_ID    = 3'b001,
        S_EXE_A = 3'b110,
        S_EXE_B = 3'b101,
        S_EXE_L = 3'b010,
        S_MEM   = 3'b011,
        S_WB_A  = 3'b111,
        S_WB_L  = 3'b100
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLTI  = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t state_q;
    logic   halt_q;

    logic is_arith, is_ls, is_br, is_jump, is_halt, is_nop, br_taken;

    always_comb begin
        is_arith = (bus.op == OP_ADD) || (bus.op == OP_SUB) || (bus.op == OP_ADDIU) ||
                   (bus.op == OP_ANDI) || (bus.op == OP_ORI) || (bus.op == OP_SLTI);
        is_ls    = (bus.op == OP_SW) || (bus.op == OP_LW);
        is_br    = (bus.op == OP_BEQ) || (bus.op == OP_BNE);
        is_jump  = (bus.op == OP_J) || (bus.op == OP_JR) || (bus.op == OP_JAL);
        is_halt  = (bus.op == OP_HALT);
        is_nop   = !(is_arith || is_ls || is_br || is_jump || is_halt);
        br_taken = ((bus.op == OP_BEQ) && bus.zero) || ((bus.op == OP_BNE) && !bus.zero);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
            halt_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IF:    state_q <= S_ID;
                S_ID: begin
                    // HALT shares the ID encoding; halt_q pins it there until reset
                    if (!halt_q) begin
                        if (is_jump || is_nop) state_q <= S_IF;
                        else if (is_br)        state_q <= S_EXE_B;
                        else if (is_ls)        state_q <= S_EXE_L;
                        else if (is_arith)     state_q <= S_EXE_A;
                        else                   halt_q  <= 1'b1;
                    end
                end
                S_EXE_A: state_q <= S_WB_A;
                S_EXE_B: state_q <= S_IF;
                S_EXE_L: state_q <= S_MEM;
                S_MEM:   state_q <= (bus.op == OP_LW) ? S_WB_L : S_IF;
                S_WB_A:  state_q <= S_IF;
                S_WB_L:  state_q <= S_IF;
                default: state_q <= S_IF;
            endcase
        end
    end

    always_comb begin
        bus.PCWre     = 1'b0;
        bus.IRWre     = 1'b0;
        bus.ExtSel    = 1'b0;
        bus.ALUSrcB   = 1'b0;
        bus.DBDataSrc = 1'b0;
        bus.RegWre    = 1'b0;
        bus.WrRegDSrc = 1'b0;
        bus.mRD       = 1'b0;
        bus.mWR       = 1'b0;
        bus.RegDst    = 2'b00;
        bus.PCSrc     = 2'b00;
        bus.ALUOp     = 3'b000;
        // Outputs are gated by Reset so the datapath sees a quiet bus while it is held low
        if (Reset) begin
            bus.IRWre     = (state_q == S_IF);
            bus.PCWre     = ((state_q == S_ID) && !halt_q && (is_jump || is_nop)) ||
                            (state_q == S_EXE_B) ||
                            ((state_q == S_MEM) && (bus.op == OP_SW)) ||
                            (state_q == S_WB_A) || (state_q == S_WB_L);
            bus.ExtSel    = !((bus.op == OP_ANDI) || (bus.op == OP_ORI));
            bus.ALUSrcB   = is_ls || (bus.op == OP_ADDIU) || (bus.op == OP_ANDI) ||
                            (bus.op == OP_ORI) || (bus.op == OP_SLTI);
            bus.DBDataSrc = (state_q == S_WB_L);
            bus.RegWre    = (state_q == S_WB_A) || (state_q == S_WB_L) ||
                            ((state_q == S_ID) && !halt_q && (bus.op == OP_JAL));
            bus.WrRegDSrc = (bus.op != OP_JAL);
            bus.mRD       = (state_q == S_MEM) && (bus.op == OP_LW);
            bus.mWR       = (state_q == S_MEM) && (bus.op == OP_SW);

            if ((bus.op == OP_ADD) || (bus.op == OP_SUB)) bus.RegDst = 2'b01;
            else if (bus.op == OP_JAL)                    bus.RegDst = 2'b10;

            if ((state_q == S_EXE_B) && br_taken)             bus.PCSrc = 2'b01;
            else if (bus.op == OP_JR)                         bus.PCSrc = 2'b10;
            else if ((bus.op == OP_J) || (bus.op == OP_JAL))  bus.PCSrc = 2'b11;

            case (bus.op)
                OP_SUB, OP_BEQ, OP_BNE: bus.ALUOp = 3'b001;
                OP_ORI:                 bus.ALUOp = 3'b011;
                OP_ANDI:                bus.ALUOp = 3'b100;
                OP_SLTI:                bus.ALUOp = 3'b110;
                default:                bus.ALUOp = 3'b000;
            endcase
        end
    end

    assign bus.state = state_q;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed scenarios plus randomized instruction
// streams checked against a cycle-index reference model.
module tb_multi_cycle_ctrl;
    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010,
                           ANDI = 6'b010000, ORI = 6'b010010, SLTI = 6'b100111,
                           SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100,
                           BNE = 6'b110101, J = 6'b111000, JR = 6'b111001,
                           JAL = 6'b111010, HALT = 6'b111111;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    multi_cycle_ctrl_if bus ();
    multi_cycle_ctrl dut (.CLK(clk), .Reset(rst_n), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, PCWre, IRWre, ExtSel, ALUSrcB, DBDataSrc, RegWre, WrRegDSrc, mRD, mWR, RegDst, PCSrc, ALUOp}
    logic [18:0] dut_vec;
    assign dut_vec = {bus.state, bus.PCWre, bus.IRWre, bus.ExtSel, bus.ALUSrcB, bus.DBDataSrc,
                      bus.RegWre, bus.WrRegDSrc, bus.mRD, bus.mWR, bus.RegDst, bus.PCSrc, bus.ALUOp};

    typedef enum int {C_J, C_BR, C_AR, C_SW, C_LW, C_HALT} cls_t;

    function automatic cls_t cls_of(input logic [5:0] op);
        case (op)
            ADD, SUB, ADDIU, ANDI, ORI, SLTI: return C_AR;
            SW:        return C_SW;
            LW:        return C_LW;
            BEQ, BNE:  return C_BR;
            HALT:      return C_HALT;
            default:   return C_J;
        endcase
    endfunction

    function automatic int len_of(input cls_t c);
        case (c)
            C_J:     return 2;
            C_BR:    return 3;
            C_AR:    return 4;
            C_SW:    return 4;
            default: return 5;
        endcase
    endfunction

    // Expected outputs on cycle k (0 = IF) of an instruction
    function automatic logic [18:0] exp_vec(input logic [5:0] op, input logic z, input int k);
        cls_t c = cls_of(op);
        bit last = (k == len_of(c) - 1);
        logic [2:0] st;
        logic [1:0] rd, ps;
        logic [2:0] alu;
        bit pcw, irw, ext, srcb, dbd, rgw, wrd, mrd, mwr;
        case (k)
            0: st = 3'b000;
            1: st = 3'b001;
            2: st = (c == C_BR) ? 3'b101 : (c == C_AR) ? 3'b110 : 3'b010;
            3: st = (c == C_AR) ? 3'b111 : 3'b011;
            default: st = 3'b100;
        endcase
        pcw  = last;
        irw  = (k == 0);
        ext  = !(op == ANDI || op == ORI);
        srcb = (op == ADDIU || op == ANDI || op == ORI || op == SLTI || op == LW || op == SW);
        dbd  = (c == C_LW) && (k == 4);
        rgw  = ((c == C_AR || c == C_LW) && last) || (op == JAL && k == 1);
        wrd  = (op != JAL);
        mrd  = (c == C_LW) && (k == 3);
        mwr  = (c == C_SW) && (k == 3);
        rd   = (op == ADD || op == SUB) ? 2'b01 : (op == JAL) ? 2'b10 : 2'b00;
        if (c == C_BR && last && ((op == BEQ && z) || (op == BNE && !z))) ps = 2'b01;
        else if (op == JR)                                                ps = 2'b10;
        else if (op == J || op == JAL)                                    ps = 2'b11;
        else                                                              ps = 2'b00;
        case (op)
            SUB, BEQ, BNE: alu = 3'b001;
            ORI:           alu = 3'b011;
            ANDI:          alu = 3'b100;
            SLTI:          alu = 3'b110;
            default:       alu = 3'b000;
        endcase
        return {st, pcw, irw, ext, srcb, dbd, rgw, wrd, mrd, mwr, rd, ps, alu};
    endfunction

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.op = JAL;
        bus.zero = 1'b1;
        #1;
        total++;
        if (dut_vec !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", dut_vec, 19'd0);
        end
        next_cyc();
        total++;
        if (dut_vec !== 19'd0) begin
            bad++;
            $display("FAIL reset_held got=%h want=%h", dut_vec, 19'd0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [2:0] seq [4] = '{3'b000, 3'b001, 3'b110, 3'b111};
        bus.op = ADD;
        bus.zero = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.state !== seq[k] || bus.RegWre !== (k == 3) || bus.PCWre !== (k == 3)) begin
                bad++;
                $display("FAIL add_cycle%0d got st=%b rw=%b pw=%b want st=%b rw=%b pw=%b",
                         k, bus.state, bus.RegWre, bus.PCWre, seq[k], k == 3, k == 3);
            end
            if (k == 3) begin
                total++;
                if (bus.RegDst !== 2'b01) begin
                    bad++;
                    $display("FAIL add_regdst got=%b want=01", bus.RegDst);
                end
            end
            next_cyc();
        end
        total++;
        if (bus.state !== 3'b000) begin
            bad++;
            $display("FAIL add_return got=%b want=000", bus.state);
        end
    endtask

    task automatic test_lw();
        logic [2:0] seq [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        bus.op = LW;
        #1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (bus.state !== seq[k] || bus.mRD !== (k == 3) || bus.DBDataSrc !== (k == 4) ||
                bus.RegWre !== (k == 4) || bus.ALUSrcB !== 1'b1 || bus.ExtSel !== 1'b1 ||
                bus.mWR !== 1'b0) begin
                bad++;
                $display("FAIL lw_cycle%0d got st=%b mrd=%b dbd=%b rw=%b srcb=%b ext=%b mwr=%b want st=%b mrd=%b dbd=%b rw=%b srcb=1 ext=1 mwr=0",
                         k, bus.state, bus.mRD, bus.DBDataSrc, bus.RegWre, bus.ALUSrcB, bus.ExtSel,
                         bus.mWR, seq[k], k == 3, k == 4, k == 4);
            end
            next_cyc();
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [2] = '{BEQ, BNE};
        for (int i = 0; i < 2; i++) begin
            for (int z = 0; z < 2; z++) begin
                logic [1:0] want;
                want = ((ops[i] == BEQ) == (z == 1)) ? 2'b01 : 2'b00;
                bus.op = ops[i];
                bus.zero = z[0];
                #1;
                next_cyc();
                next_cyc();
                total++;
                if (bus.state !== 3'b101 || bus.PCSrc !== want || bus.PCWre !== 1'b1) begin
                    bad++;
                    $display("FAIL branch op=%b z=%0d got st=%b pcsrc=%b pw=%b want st=101 pcsrc=%b pw=1",
                             ops[i], z, bus.state, bus.PCSrc, bus.PCWre, want);
                end
                next_cyc();
            end
        end
    endtask

    task automatic test_jal_ori();
        bus.op = JAL;
        #1;
        next_cyc();
        total++;
        if (bus.state !== 3'b001 || bus.PCSrc !== 2'b11 || bus.RegWre !== 1'b1 ||
            bus.RegDst !== 2'b10 || bus.WrRegDSrc !== 1'b0 || bus.PCWre !== 1'b1) begin
            bad++;
            $display("FAIL jal_id got st=%b pcsrc=%b rw=%b rd=%b wrd=%b pw=%b want 001 11 1 10 0 1",
                     bus.state, bus.PCSrc, bus.RegWre, bus.RegDst, bus.WrRegDSrc, bus.PCWre);
        end
        next_cyc();
        total++;
        if (bus.state !== 3'b000) begin
            bad++;
            $display("FAIL jal_return got=%b want=000", bus.state);
        end
        bus.op = ORI;
        #1;
        next_cyc();
        next_cyc();
        total++;
        if (bus.ExtSel !== 1'b0 || bus.ALUOp !== 3'b011 || bus.state !== 3'b110) begin
            bad++;
            $display("FAIL ori_exe got ext=%b aluop=%b st=%b want 0 011 110",
                     bus.ExtSel, bus.ALUOp, bus.state);
        end
        next_cyc();
        next_cyc();
    endtask

    task automatic test_nop();
        bus.op = 6'b101010;
        #1;
        next_cyc();
        total++;
        if (bus.state !== 3'b001 || bus.PCWre !== 1'b1 || bus.RegWre !== 1'b0 ||
            bus.mRD !== 1'b0 || bus.mWR !== 1'b0 || bus.IRWre !== 1'b0) begin
            bad++;
            $display("FAIL nop_id got st=%b pw=%b rw=%b mrd=%b mwr=%b irw=%b want 001 1 0 0 0 0",
                     bus.state, bus.PCWre, bus.RegWre, bus.mRD, bus.mWR, bus.IRWre);
        end
        next_cyc();
        total++;
        if (bus.state !== 3'b000) begin
            bad++;
            $display("FAIL nop_return got=%b want=000", bus.state);
        end
    endtask

    task automatic test_reset_mid_sw();
        bus.op = SW;
        #1;
        next_cyc();
        next_cyc();
        next_cyc();
        total++;
        if (bus.state !== 3'b011 || bus.mWR !== 1'b1) begin
            bad++;
            $display("FAIL sw_mem got st=%b mwr=%b want 011 1", bus.state, bus.mWR);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.mWR !== 1'b0 || bus.state !== 3'b000) begin
            bad++;
            $display("FAIL sw_reset_async got mwr=%b st=%b want 0 000", bus.mWR, bus.state);
        end
        next_cyc();
        rst_n = 1'b1;
        next_cyc();
        total++;
        if (bus.state !== 3'b001) begin
            bad++;
            $display("FAIL sw_reset_resume got=%b want=001", bus.state);
        end
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [5:0] ops [13] = '{ADD, SUB, ADDIU, ANDI, ORI, SLTI, SW, LW, BEQ, BNE, J, JR, JAL};
        for (int n = 0; n < 120; n++) begin
            logic [5:0] op;
            logic       z;
            int         len;
            if ($urandom_range(0, 4) == 0) begin
                op = 6'($urandom);
                if (op == HALT) op = 6'b101010;
            end else begin
                op = ops[$urandom_range(0, 12)];
            end
            z = 1'($urandom);
            bus.op = op;
            bus.zero = z;
            #1;
            len = len_of(cls_of(op));
            for (int k = 0; k < len; k++) begin
                logic [18:0] want;
                want = exp_vec(op, z, k);
                total++;
                if (dut_vec !== want) begin
                    bad++;
                    $display("FAIL random op=%b z=%b cycle=%0d got=%b want=%b", op, z, k, dut_vec, want);
                end
                next_cyc();
            end
        end
    endtask

    task automatic test_halt();
        bus.op = HALT;
        #1;
        next_cyc();
        for (int k = 0; k < 12; k++) begin
            total++;
            if (bus.state !== 3'b001 || bus.PCWre !== 1'b0 || bus.RegWre !== 1'b0 || bus.IRWre !== 1'b0) begin
                bad++;
                $display("FAIL halt_hold cycle=%0d got st=%b pw=%b rw=%b irw=%b want 001 0 0 0",
                         k, bus.state, bus.PCWre, bus.RegWre, bus.IRWre);
            end
            next_cyc();
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (dut_vec !== 19'd0) begin
            bad++;
            $display("FAIL halt_reset got=%h want=%h", dut_vec, 19'd0);
        end
        next_cyc();
        rst_n = 1'b1;
        bus.op = ADD;
        next_cyc();
        total++;
        if (bus.state !== 3'b001) begin
            bad++;
            $display("FAIL halt_release got=%b want=001", bus.state);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus.op = 6'b0;
        bus.zero = 1'b0;
        next_cyc();
        test_reset();
        test_add();
        test_lw();
        test_branch();
        test_jal_ori();
        test_nop();
        test_reset_mid_sw();
        test_random();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port op, input, 6 bits: opcode from the instruction register, stable from ID onward.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-005 SHALL have outputs PCWre, IRWre, ExtSel, ALUSrcB, DBDataSrc, RegWre, WrRegDSrc, mRD and mWR, each 1 bit: datapath enables and selects.
REQ-006 SHALL have outputs RegDst (2 bits), PCSrc (2 bits) and ALUOp (3 bits).
REQ-007 SHALL have output state, 3 bits: current FSM state, for debug.

Function
REQ-008 SHALL decode these opcodes: add 000000, sub 000001, addiu 000010, andi 010000, ori 010010, slti 100111, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111.
REQ-009 SHALL treat any other opcode as a NOP: ID -> IF with PCWre=1 and no other writes.
REQ-010 SHALL use this state encoding: IF 000, ID 001, EXE_A 110, EXE_B 101, EXE_L 010, MEM 011, WB_A 111, WB_L 100; HALT reuses 001 with an internal halt flag set.
REQ-011 SHALL take these transitions:
- IF -> ID always.
- ID: j/jr/jal -> IF; beq/bne -> EXE_B; lw/sw -> EXE_L; add/sub/addiu/andi/ori/slti -> EXE_A; halt -> HALT.
REQ-012 SHALL continue the transitions:
- EXE_A -> WB_A -> IF; EXE_B -> IF; EXE_L -> MEM.
- MEM: lw -> WB_L, sw -> IF; WB_L -> IF.
- HALT stays in HALT until reset.
REQ-013 SHALL compute outputs combinationally from state and op (Moore on state, qualified by op).
REQ-014 SHALL assert IRWre only in IF.
REQ-015 SHALL assert PCWre only on the final cycle of each instruction:
- ID for j/jr/jal/NOP, EXE_B, MEM for sw, WB_A, WB_L.
- Never in HALT.
REQ-016 SHALL latency per instruction class: j/jr/jal/NOP 2 cycles; beq/bne 3; R/I-arith 4; sw 4; lw 5.
REQ-017 SHALL drive ExtSel=0 for andi and ori, and ExtSel=1 for all other opcodes.
REQ-018 SHALL drive ALUSrcB=1 for addiu, andi, ori, slti, lw and sw; 0 otherwise.
REQ-019 SHALL drive ALUOp: add/addiu/lw/sw 000; sub/beq/bne 001; ori 011; andi 100; slti 110; others 000.
REQ-020 SHALL drive PCSrc: 00 PC+4 by default; 01 in EXE_B when (beq & zero) | (bne & ~zero); 10 for jr; 11 for j/jal.
REQ-021 SHALL assert RegWre only in WB_A, WB_L, and in ID for jal.
REQ-022 SHALL drive RegDst: 01 (rd) for add/sub; 10 ($31) for jal; 00 (rt) otherwise.
REQ-023 SHALL drive WrRegDSrc=0 for jal (writes PC+4) and 1 otherwise.
REQ-024 SHALL drive DBDataSrc=1 in WB_L and 0 otherwise.
REQ-025 SHALL assert mRD only in MEM for lw, and mWR only in MEM for sw; mRD and mWR SHALL never be asserted together.

Reset
REQ-026 SHALL force state to IF and clear the halt flag immediately when Reset is low, independent of CLK.
REQ-027 SHALL hold PCWre, IRWre, RegWre, mRD and mWR at 0 while Reset is low; all other outputs 0 and state 000.
REQ-028 SHALL abandon an in-flight instruction when reset is asserted mid-instruction; the first edge after release enters ID from IF.

Verification
REQ-029 SHALL pass: add after reset -> states 000,001,110,111,000; RegWre=1 and RegDst=01 only in WB_A; PCWre=1 only in WB_A.
REQ-030 SHALL pass: lw -> states 000,001,010,011,100; mRD=1 in MEM; DBDataSrc=1 and RegWre=1 in WB_L; ALUSrcB=1, ExtSel=1.
REQ-031 SHALL pass: beq with zero=1 -> EXE_B with PCSrc=01, PCWre=1; repeated with zero=0 -> PCSrc=00; bne mirrors this.
REQ-032 SHALL pass: jal -> ID with PCSrc=11, RegWre=1, RegDst=10, WrRegDSrc=0, then IF; ori -> ExtSel=0, ALUOp=011.
REQ-033 SHALL pass: halt -> state 001 held for 10+ cycles with PCWre=0; Reset low -> state 000 without a clock edge.
REQ-034 SHALL pass: Reset pulsed low during MEM of sw -> mWR drops immediately; undefined opcode 101010 -> 2-cycle NOP with no writes.
